// File: rtl/note_pkg.sv
// Shared note definitions for the tone path: note codes, frequency table and
// the half-period thresholds used to decode a measured tone back into a note.
package note_pkg;

    localparam int unsigned PERIOD_W    = 20;
    localparam int unsigned NOTE_CNT    = 7;
    localparam int unsigned CLK_MHZ_DEF = 25;

    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [2:0] {
        NOTE_A = 3'd0,
        NOTE_B = 3'd1,
        NOTE_C = 3'd2,
        NOTE_D = 3'd3,
        NOTE_E = 3'd4,
        NOTE_F = 3'd5,
        NOTE_G = 3'd6
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED
    } det_state_e;

    // Tone frequencies in Hz, indexed by note code (A at index 0).
    localparam logic [NOTE_CNT-1:0][15:0] FREQ_HZ = {
        16'd392, 16'd349, 16'd330, 16'd294, 16'd261, 16'd247, 16'd220
    };

    // Boundaries between adjacent notes; entry i separates note i from note i+1.
    typedef logic [NOTE_CNT-2:0][PERIOD_W-1:0] mid_table_t;

    function automatic int unsigned hp_of(input int unsigned clk_mhz, input int unsigned idx);
        return (clk_mhz * 32'd1000000) / int'(FREQ_HZ[idx]) / 2;
    endfunction

    function automatic mid_table_t mid_table(input int unsigned clk_mhz);
        mid_table_t t;
        for (int i = 0; i < NOTE_CNT - 1; i++) begin
            t[i] = period_t'((hp_of(clk_mhz, i) + hp_of(clk_mhz, i + 1)) / 2);
        end
        return t;
    endfunction

    function automatic period_t g_lo_of(input int unsigned clk_mhz);
        return period_t'(hp_of(clk_mhz, 6) - (hp_of(clk_mhz, 5) - hp_of(clk_mhz, 6)) / 2);
    endfunction

    function automatic period_t a_hi_of(input int unsigned clk_mhz);
        return period_t'(hp_of(clk_mhz, 0) + (hp_of(clk_mhz, 0) - hp_of(clk_mhz, 1)) / 2);
    endfunction

    // Nominal constants for the default system clock.
    localparam period_t HP_A = period_t'(hp_of(CLK_MHZ_DEF, 0));
    localparam period_t HP_B = period_t'(hp_of(CLK_MHZ_DEF, 1));
    localparam period_t HP_C = period_t'(hp_of(CLK_MHZ_DEF, 2));
    localparam period_t HP_D = period_t'(hp_of(CLK_MHZ_DEF, 3));
    localparam period_t HP_E = period_t'(hp_of(CLK_MHZ_DEF, 4));
    localparam period_t HP_F = period_t'(hp_of(CLK_MHZ_DEF, 5));
    localparam period_t HP_G = period_t'(hp_of(CLK_MHZ_DEF, 6));

    localparam mid_table_t MID  = mid_table(CLK_MHZ_DEF);
    localparam period_t    G_LO = g_lo_of(CLK_MHZ_DEF);
    localparam period_t    A_HI = a_hi_of(CLK_MHZ_DEF);

endpackage

// File: rtl/note_classifier.sv
// Combinational half-period classifier: maps a measured interval to a note code
// and flags intervals outside the A..G window.
module note_classifier
    import note_pkg::*;
#(
    parameter int unsigned CLK_MHZ = CLK_MHZ_DEF
) (
    input  logic [PERIOD_W-1:0] hp,
    output logic                in_range,
    output logic [2:0]          note_class
);

    localparam mid_table_t MID_T  = mid_table(CLK_MHZ);
    localparam period_t    G_LO_T = g_lo_of(CLK_MHZ);
    localparam period_t    A_HI_T = a_hi_of(CLK_MHZ);

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        in_range   = (hp >= G_LO_T) && (hp < A_HI_T);
        note_class = 3'(NOTE_A);
        // Boundaries shrink with rising index, so the last hit is the closest note;
        // an interval equal to a boundary stays with the longer-period note.
        for (int i = 0; i < NOTE_CNT - 1; i++) begin
            if (hp < MID_T[i]) begin
                note_class = 3'(i + 1);
            end
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures the half-period of an asynchronous square-wave tone and decodes it to
// note A..G with lock/timeout. Define NOTE_DET_HYST_EN to hold lock through mismatches.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned CLK_MHZ     = CLK_MHZ_DEF,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TIMEOUT_CYC = 131072
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soundWave,
    output logic [2:0]          note,
    output logic                note_valid,
    output logic                note_change,
    output logic [PERIOD_W-1:0] half_period
);

    localparam period_t    TIMEOUT_VAL = period_t'(TIMEOUT_CYC);
    localparam logic [3:0] LOCK_VAL    = 4'(LOCK_COUNT);

    logic       sync1, sync2, prev, edge_pulse;
    period_t    cnt;
    logic [3:0] match, match_next;
    logic [2:0] cand;
    logic       cls_in_range, same_cand, lock_hit;
    logic [2:0] cls_note;
    det_state_e state;

`ifdef NOTE_DET_HYST_EN
    logic [2:0] alt_cand;
    logic [3:0] alt_match, alt_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= soundWave;
            sync2      <= sync1;
            prev       <= sync2;
            edge_pulse <= sync2 ^ prev;
        end
    end

    note_classifier #(.CLK_MHZ(CLK_MHZ)) u_classifier (
        .hp         (cnt),
        .in_range   (cls_in_range),
        .note_class (cls_note)
    );

    always_comb begin
        same_cand = cls_in_range && (cls_note == cand);
        if (same_cand) begin
            match_next = match + 4'd1;
        end else if (cls_in_range) begin
            match_next = 4'd1;
        end else begin
            match_next = 4'd0;
        end
        lock_hit = cls_in_range && (match_next == LOCK_VAL);
    end

`ifdef NOTE_DET_HYST_EN
    always_comb begin
        if ((alt_match != 4'd0) && (cls_note == alt_cand)) begin
            alt_next = alt_match + 4'd1;
        end else begin
            alt_next = 4'd1;
        end
    end
`endif

    // NOTE: only control and output registers are reset; the classifier has no storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            match       <= '0;
            cand        <= '0;
            note        <= '0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
            half_period <= '0;
`ifdef NOTE_DET_HYST_EN
            alt_cand    <= '0;
            alt_match   <= '0;
`endif
        end else begin
            note_change <= 1'b0;
            if (state == ST_IDLE) begin
                // The partial interval before the first edge is never classified.
                cnt        <= edge_pulse ? period_t'(1) : '0;
                match      <= '0;
                note_valid <= 1'b0;
                if (edge_pulse) begin
                    state <= ST_MEASURE;
                end
            end else if (edge_pulse) begin
                cnt         <= period_t'(1);
                half_period <= cnt;
                case (state)
                    ST_MEASURE: begin
                        match <= match_next;
                        if (!same_cand) begin
                            cand <= cls_note;
                        end
                        if (lock_hit) begin
                            note        <= cls_note;
                            note_valid  <= 1'b1;
                            note_change <= 1'b1;
                            state       <= ST_LOCKED;
`ifdef NOTE_DET_HYST_EN
                            alt_match   <= '0;
`endif
                        end
                    end
                    ST_LOCKED: begin
`ifdef NOTE_DET_HYST_EN
                        // Lock is kept; a new note must be confirmed by agreeing mismatches.
                        if (cls_in_range && (cls_note != note)) begin
                            alt_cand <= cls_note;
                            if (alt_next == LOCK_VAL) begin
                                note        <= cls_note;
                                note_change <= 1'b1;
                                alt_match   <= '0;
                            end else begin
                                alt_match <= alt_next;
                            end
                        end else begin
                            alt_match <= '0;
                        end
`else
                        if (!(cls_in_range && (cls_note == note))) begin
                            note_valid <= 1'b0;
                            cand       <= cls_note;
                            match      <= cls_in_range ? 4'd1 : 4'd0;
                            state      <= ST_MEASURE;
                        end
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (cnt >= TIMEOUT_VAL) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                match      <= '0;
                note_valid <= 1'b0;
`ifdef NOTE_DET_HYST_EN
                alt_match  <= '0;
`endif
            end else if (cnt != '1) begin
                cnt <= cnt + period_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: classifier threshold table at 25 MHz plus
// lock, timeout, out-of-range, note switch and reset sequences on a 1 MHz instance.
module tb_note_detector;

    localparam int unsigned CLK_MHZ = 1;
    localparam int unsigned LOCK    = 4;
    localparam int unsigned TIMEOUT = 4000;
    // At 1 MHz: HP_A=2272, HP_G=1275, G_LO=1197, A_HI=2396.
    localparam int HP_A_IN = 2273;
    localparam int HP_G_IN = 1276;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sound_wave = 1'b0;
    logic [2:0]  note;
    logic        note_valid, note_change;
    logic [19:0] half_period;

    logic [19:0] cl_hp = '0;
    logic        cl_in_range;
    logic [2:0]  cl_note;

    int tests = 0;
    int fails = 0;
    int nc_count = 0;
    int gen_hp = 0;
    int gen_cnt = 0;
    int toggles = 0;
    bit gen_clear = 1'b0;
    int base;

    always #5 clk = ~clk;

    note_detector #(.CLK_MHZ(CLK_MHZ), .LOCK_COUNT(LOCK), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soundWave   (sound_wave),
        .note        (note),
        .note_valid  (note_valid),
        .note_change (note_change),
        .half_period (half_period)
    );

    note_classifier #(.CLK_MHZ(25)) u_cls25 (
        .hp         (cl_hp),
        .in_range   (cl_in_range),
        .note_class (cl_note)
    );

    always @(posedge clk) begin
        if (note_change) nc_count <= nc_count + 1;
    end

    // Tone source: toggles every gen_hp clocks, so each measured interval is gen_hp.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gen_clear) begin
                sound_wave = 1'b0;
                gen_cnt    = 0;
            end else if (gen_hp == 0) begin
                gen_cnt = 0;
            end else begin
                gen_cnt++;
                if (gen_cnt >= gen_hp) begin
                    sound_wave = ~sound_wave;
                    toggles++;
                    gen_cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_toggles(input int target);
        int budget = 20000;
        while (toggles < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("gen_wait", 32'(toggles >= target), 32'd1);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [19:0] hp;
        logic        in_range;
        logic [2:0]  note;
    } cls_vec_t;

    cls_vec_t vecs[18];

    initial begin
        vecs = '{
            '{20'd56819, 1'b1, 3'd0}, '{20'd53712, 1'b1, 3'd0}, '{20'd53711, 1'b1, 3'd1},
            '{20'd49249, 1'b1, 3'd1}, '{20'd49248, 1'b1, 3'd2}, '{20'd47892, 1'b1, 3'd2},
            '{20'd42517, 1'b1, 3'd3}, '{20'd37878, 1'b1, 3'd4}, '{20'd35816, 1'b1, 3'd5},
            '{20'd33851, 1'b1, 3'd5}, '{20'd33850, 1'b1, 3'd6}, '{20'd31888, 1'b1, 3'd6},
            '{20'd29923, 1'b1, 3'd6}, '{20'd29922, 1'b0, 3'd0}, '{20'd59922, 1'b1, 3'd0},
            '{20'd59923, 1'b0, 3'd0}, '{20'd20000, 1'b0, 3'd0}, '{20'd65000, 1'b0, 3'd0}
        };

        for (int i = 0; i < 18; i++) begin
            cl_hp = vecs[i].hp;
            #1;
            check($sformatf("cls_range[%0d]", vecs[i].hp), 32'(cl_in_range), 32'(vecs[i].in_range));
            if (vecs[i].in_range) begin
                check($sformatf("cls_note[%0d]", vecs[i].hp), 32'(cl_note), 32'(vecs[i].note));
            end
        end

        repeat (3) @(negedge clk);
        check("rst_note", 32'(note), 0);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_change", 32'(note_change), 0);
        check("rst_hp", 32'(half_period), 0);
        rst_n = 1'b1;

        // Lock on A: the 1st edge only starts measuring, 4 more intervals lock.
        base = toggles;
        gen_hp = HP_A_IN;
        wait_toggles(base + 4);
        settle();
        check("a_prelock_valid", 32'(note_valid), 0);
        wait_toggles(base + 5);
        gen_hp = 0;
        settle();
        check("a_lock_valid", 32'(note_valid), 1);
        check("a_lock_note", 32'(note), 0);
        check("a_lock_hp", 32'(half_period), 32'(HP_A_IN));
        check("a_lock_changes", 32'(nc_count), 1);

        // Input stops: lock holds until the timeout, note keeps its value.
        repeat (TIMEOUT - 100) @(negedge clk);
        check("to_before_valid", 32'(note_valid), 1);
        repeat (120) @(negedge clk);
        check("to_after_valid", 32'(note_valid), 0);
        check("to_after_note", 32'(note), 0);

        // Out-of-range intervals never lock; first edge from idle is not measured.
        base = toggles;
        gen_hp = 1000;
        wait_toggles(base + 1);
        settle();
        check("idle_first_edge_hp", 32'(half_period), 32'(HP_A_IN));
        for (int k = 2; k <= 4; k++) begin
            wait_toggles(base + k);
            settle();
            check("short_hp", 32'(half_period), 1000);
            check("short_valid", 32'(note_valid), 0);
        end
        gen_hp = 2500;
        for (int k = 5; k <= 8; k++) begin
            wait_toggles(base + k);
            settle();
            check("long_hp", 32'(half_period), 2500);
            check("long_valid", 32'(note_valid), 0);
        end
        gen_hp = 0;
        repeat (TIMEOUT + 50) @(negedge clk);

        // Relock on A, then switch to G.
        base = toggles;
        gen_hp = HP_A_IN;
        wait_toggles(base + 5);
        settle();
        check("relock_valid", 32'(note_valid), 1);
        check("relock_note", 32'(note), 0);
        check("relock_changes", 32'(nc_count), 2);
        gen_hp = HP_G_IN;
        for (int k = 6; k <= 8; k++) begin
            wait_toggles(base + k);
            settle();
            check("g_hp", 32'(half_period), 32'(HP_G_IN));
`ifdef NOTE_DET_HYST_EN
            check("g_hold_valid", 32'(note_valid), 1);
            check("g_hold_note", 32'(note), 0);
`else
            check("g_drop_valid", 32'(note_valid), 0);
`endif
        end
        wait_toggles(base + 9);
        settle();
        check("g_lock_valid", 32'(note_valid), 1);
        check("g_lock_note", 32'(note), 6);
        check("g_lock_changes", 32'(nc_count), 3);

        // Reset while locked clears outputs at once; relock needs 1+LOCK fresh edges.
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(note_valid), 0);
        check("mid_rst_note", 32'(note), 0);
        check("mid_rst_hp", 32'(half_period), 0);
        gen_hp = 0;
        gen_clear = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gen_clear = 1'b0;
        base = toggles;
        gen_hp = HP_A_IN;
        wait_toggles(base + 4);
        settle();
        check("post_rst_prelock", 32'(note_valid), 0);
        wait_toggles(base + 5);
        settle();
        check("post_rst_valid", 32'(note_valid), 1);
        check("post_rst_note", 32'(note), 0);
        check("post_rst_hp", 32'(half_period), 32'(HP_A_IN));
        gen_hp = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
